// File: rtl/card_game_controller_if.sv
// Select/cursor inputs and flat game-state outputs of the pair-game controller.
// master = input/cursor + VGA side, slave = card_game_controller.
interface card_game_controller_if #(
  parameter int NUM_CARDS = 20
);
  logic                   select_pulse;
  logic [4:0]             cursor_pos;
  logic [5*NUM_CARDS-1:0] card_order;
  logic [NUM_CARDS-1:0]   is_flipped;
  logic [NUM_CARDS-1:0]   is_out;
  logic [3:0]             vidas;
  logic                   busy;
  logic                   game_over;
  logic                   win;

  modport master (
    output select_pulse, cursor_pos,
    input  card_order, is_flipped, is_out,
    input  vidas, busy, game_over, win
  );

  modport slave (
    input  select_pulse, cursor_pos,
    output card_order, is_flipped, is_out,
    output vidas, busy, game_over, win
  );
endinterface

// File: rtl/card_game_controller.sv
// Memory-pair game sequencer: LFSR Fisher-Yates shuffle, two-card reveal, lives.
// SHOW_SKIP_EN: a select during SHOW ends the reveal early.
module card_game_controller #(
  parameter int          NUM_CARDS     = 20,
  parameter int          VIDAS_INICIAL = 10,
  parameter int          SHOW_CYCLES   = 50_000_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic clock_50M,
  input logic rst_n,
  card_game_controller_if.slave bus
);

  localparam int TW =
    (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(SHOW_CYCLES - 1);
  localparam logic [5:0] NC6 = 6'(NUM_CARDS);
  localparam logic [4:0] ILAST = 5'(NUM_CARDS - 1);
  localparam logic [3:0] VINIT = 4'(VIDAS_INICIAL);

  typedef enum logic [2:0] {
    WAIT_START,
    SHUFFLE,
    IDLE,
    ONE,
    SHOW,
    RESOLVE,
    END
  } state_t;

  state_t state, state_d;

  logic [4:0]           order [NUM_CARDS];
  logic [NUM_CARDS-1:0] flip_r;
  logic [NUM_CARDS-1:0] out_r;
  logic [NUM_CARDS-1:0] out_nxt;
  logic [3:0]           vidas_r;
  logic                 win_r;
  logic                 busy_r;
  logic                 over_r;
  logic [15:0]          lfsr;
  logic [4:0]           idx;
  logic [4:0]           first;
  logic [4:0]           second;
  logic [TW-1:0]        timer;
  logic [12:0]          prod;
  logic [4:0]           k;
  logic                 sel_ok;
  logic                 match;
  logic                 all_out;
  logic                 lose;
  logic                 show_done;
  logic [5*NUM_CARDS-1:0] order_flat;

  // Decode select validity, swap index and resolve outcome.
  always_comb begin
    prod = 13'(lfsr[7:0]) * 13'({1'b0, idx} + 6'd1);
    k = 5'(prod >> 8);
    sel_ok = bus.select_pulse
      && ({1'b0, bus.cursor_pos} < NC6)
      && !flip_r[bus.cursor_pos]
      && !out_r[bus.cursor_pos];
    match = (order[first] ^ order[second]) == 5'd1;
    out_nxt = out_r;
    out_nxt[first] = 1'b1;
    out_nxt[second] = 1'b1;
    all_out = match && (&out_nxt);
    lose = !match && (vidas_r < 4'd2);
`ifdef SHOW_SKIP_EN
    show_done = (timer == '0) || bus.select_pulse;
`else
    show_done = (timer == '0);
`endif
  end

  // State register.
  always_ff @(posedge clock_50M or negedge rst_n) begin
    if (!rst_n) state <= WAIT_START;
    else        state <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state;
    unique case (state)
      WAIT_START: if (bus.select_pulse) state_d = SHUFFLE;
      SHUFFLE:    if (idx == 5'd1) state_d = IDLE;
      IDLE:       if (sel_ok) state_d = ONE;
      ONE:        if (sel_ok) state_d = SHOW;
      SHOW:       if (show_done) state_d = RESOLVE;
      RESOLVE: begin
        if (all_out || lose) state_d = END;
        else                 state_d = IDLE;
      end
      END:        if (bus.select_pulse) state_d = SHUFFLE;
      default:    state_d = WAIT_START;
    endcase
  end

  // Game datapath: deck, flags, lives, timer, LFSR.
  always_ff @(posedge clock_50M or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_CARDS; p++) order[p] <= 5'(p);
      flip_r  <= '0;
      out_r   <= '0;
      vidas_r <= VINIT;
      win_r   <= 1'b0;
      busy_r  <= 1'b0;
      over_r  <= 1'b0;
      lfsr    <= LFSR_SEED;
      idx     <= '0;
      first   <= '0;
      second  <= '0;
      timer   <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      busy_r <= (state_d == SHUFFLE) || (state_d == SHOW)
        || (state_d == RESOLVE);
      over_r <= (state_d == END);
      case (state)
        WAIT_START: begin
          if (bus.select_pulse) begin
            for (int p = 0; p < NUM_CARDS; p++) order[p] <= 5'(p);
            idx <= ILAST;
          end
        end
        SHUFFLE: begin
          order[idx] <= order[k];
          order[k]   <= order[idx];
          idx <= idx - 5'd1;
        end
        IDLE: begin
          if (sel_ok) begin
            flip_r[bus.cursor_pos] <= 1'b1;
            first <= bus.cursor_pos;
          end
        end
        ONE: begin
          if (sel_ok) begin
            flip_r[bus.cursor_pos] <= 1'b1;
            second <= bus.cursor_pos;
            timer <= TLOAD;
          end
        end
        SHOW: begin
          if (timer != '0) timer <= timer - 1'b1;
        end
        RESOLVE: begin
          flip_r[first]  <= 1'b0;
          flip_r[second] <= 1'b0;
          if (match) out_r <= out_nxt;
          else if (vidas_r != 4'd0) vidas_r <= vidas_r - 4'd1;
          if (all_out) win_r <= 1'b1;
        end
        END: begin
          if (bus.select_pulse) begin
            for (int p = 0; p < NUM_CARDS; p++) order[p] <= 5'(p);
            flip_r  <= '0;
            out_r   <= '0;
            vidas_r <= VINIT;
            win_r   <= 1'b0;
            idx     <= ILAST;
          end
        end
        default: ;
      endcase
    end
  end

  // Flatten the deck for the paint logic.
  always_comb begin
    order_flat = '0;
    for (int p = 0; p < NUM_CARDS; p++)
      order_flat[5*p +: 5] = order[p];
  end

  assign bus.card_order = order_flat;
  assign bus.is_flipped = flip_r;
  assign bus.is_out     = out_r;
  assign bus.vidas      = vidas_r;
  assign bus.busy       = busy_r;
  assign bus.game_over  = over_r;
  assign bus.win        = win_r;

endmodule
